riscv_multicycle_control: RTL
=============================

Name:
riscv_multicycle_control

Overview:
- Multicycle control unit for the RV64I core generation that follows the single-cycle core.
- Sequences each instruction over 3–5 states and drives the datapath enables and muxes.
- Talks to one unified instruction/data memory port through a req/ready handshake, so memory may insert wait states.
- Also counts retired instructions and halts in a trap state on illegal opcodes.

Parameters:
- WIDTH, 64: width of the retired-instruction counter (matches core XLEN).
- TIMEOUT_CYCLES, 255: memory-wait watchdog limit. Used only with RV_MC_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- instruction  in  32  current instruction register contents from the datapath.
- zero  in  1  ALU zero flag.
- memReady  in  1  memory completes the pending access this cycle.
- memReq  out  1  memory access request.
- memWe  out  1  1 = store, 0 = read.
- memAddrSel  out  1  memory address source: 0 = PC, 1 = ALUOut.
- irWrite  out  1  load the instruction register.
- pcWrite  out  1  load the PC.
- pcSrc  out  1  PC source: 0 = ALU result, 1 = ALUOut register.
- aluSrcA  out  2  ALU A source: 0 = PC, 1 = oldPC, 2 = rs1.
- aluSrcB  out  2  ALU B source: 0 = rs2, 1 = imm, 2 = constant 4.
- aluControl  out  4  ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9.
- regWrite  out  1  register file write enable.
- wbSel  out  2  write-back source: 0 = ALUOut, 1 = memData, 2 = PC.
- retired  out  WIDTH  retired-instruction count.
- illegal  out  1  sticky illegal-opcode flag.
- timeout  out  1  sticky watchdog flag (tied 0 without the macro).
- state  out  4  current state, for debug.

Behaviour:
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWR=4, MEMWB=5, EXEC=6, ALUWB=7, BRANCH=8, JAL=9, TRAP=10.
- Reset (asynchronous, immediate): state=FETCH, retired=0, illegal=0, timeout=0. All enables and memReq deassert while rst is high.
- Outputs are decoded combinationally from state and instruction. Unlisted outputs are 0; aluControl defaults to ADD.
- FETCH:
  - memReq=1, memAddrSel=0, aluSrcA=0, aluSrcB=2.
  - In the cycle memReady=1: irWrite=1, pcWrite=1, pcSrc=0, next state DECODE. Otherwise stay.
- DECODE:
  - aluSrcA=1, aluSrcB=1 (branch/JAL target latched into ALUOut).
  - Next state by opcode: 0000011 or 0100011 → MEMADR; 0110011 or 0010011 → EXEC; 1100011 → BRANCH; 1101111 → JAL; any other → TRAP.
- MEMADR: aluSrcA=2, aluSrcB=1. Next MEMRD for a load, MEMWR for a store.
- MEMRD: memReq=1, memAddrSel=1. Wait for memReady, then MEMWB.
- MEMWR: memReq=1, memWe=1, memAddrSel=1. Wait for memReady; in that cycle pulse the retire signal, next FETCH.
- MEMWB: regWrite=1, wbSel=1, retire, next FETCH.
- EXEC:
  - aluSrcA=2; aluSrcB=0 for R-type, 1 for I-type.
  - aluControl from funct3 and instruction[30]:
    - 000: ADD, or SUB when R-type and bit30=1.
    - 001: SLL. 010: SLT. 011: SLTU. 100: XOR.
    - 101: SRL, or SRA when bit30=1.
    - 110: OR. 111: AND.
  - Next ALUWB.
- ALUWB: regWrite=1, wbSel=0, retire, next FETCH.
- BRANCH:
  - aluSrcA=2, aluSrcB=0, aluControl=SUB, pcSrc=1.
  - pcWrite=zero when funct3=000 (beq); pcWrite=!zero when funct3=001 (bne); any other funct3 → TRAP with illegal=1, no retire.
  - Otherwise retire, next FETCH.
- JAL: regWrite=1, wbSel=2, pcWrite=1, pcSrc=1, retire, next FETCH.
- TRAP: absorbing until rst. illegal=1, no requests, retired frozen.
- Handshake rules:
  - memReq, memWe and memAddrSel stay stable until memReady is sampled high.
  - memReady is ignored while memReq=0.
  - Reset during a wait aborts the access and returns to FETCH.
- Latency with zero wait states: ALU op 4 cycles, load 5, store 4, branch 3, JAL 3.
- retired increments by 1 on each retire cycle and wraps modulo 2^WIDTH.

Optional Feature:
- Macro: RV_MC_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to FETCH, MEMRD or MEMWR and counts each cycle memReq=1 and memReady=0.
  - When it reaches TIMEOUT_CYCLES: go to TRAP with timeout=1 (sticky) and illegal=0.
- When undefined: no counter, timeout tied 0, memory waits are unbounded.

Test Plan:
- addi x1,x0,5 (0x00500093), memReady=1:
  - state sequence 0,1,6,7,0.
  - EXEC: aluSrcB=1, aluControl=0.
  - ALUWB: regWrite pulse, wbSel=0.
  - retired goes 0→1.
- ld x2,0(x1) (0x0000B103), memReady held low 3 cycles in MEMRD:
  - memReq high 4 cycles with memAddrSel=1 and memWe=0.
  - MEMWB: regWrite with wbSel=1.
  - 8 cycles total.
- beq x0,x0,8 (0x00000463):
  - zero=1 → pcWrite=1 and pcSrc=1 in BRANCH.
  - zero=0 → pcWrite=0.
  - bne (0x00001463) gives the inverse.
- sub x0,x1,x2 (0x40208033) → aluControl=1; add (0x00208033) → 0; srai (0x4010D093) → 7.
- Opcode 0x00000000:
  - DECODE→TRAP, illegal=1, memReq stays 0 for 20 cycles.
  - rst pulse → state=0, illegal=0.
  - rst asserted mid-MEMRD wait → memReq drops the same cycle.
- With RV_MC_TIMEOUT_EN and memReady held 0 in FETCH: TRAP after 255 cycles, timeout=1. Without the macro: still FETCH after 1000 cycles.

Source files
------------

// File: rtl/riscv_multicycle_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : riscv_multicycle_control                                        |
// | Purpose  : Multicycle RV64I control FSM. Sequences fetch/decode/execute    |
// |            over 3-5 states, drives datapath enables and muxes, handshakes  |
// |            with a unified memory port, counts retired instructions and     |
// |            traps on illegal opcodes.                                       |
// | Options  : RV_MC_TIMEOUT_EN enables the memory-wait watchdog.              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module riscv_multicycle_control #(
  parameter int WIDTH          = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instruction,
  input  logic             zero,
  input  logic             memReady,
  output logic             memReq,
  output logic             memWe,
  output logic             memAddrSel,
  output logic             irWrite,
  output logic             pcWrite,
  output logic             pcSrc,
  output logic [1:0]       aluSrcA,
  output logic [1:0]       aluSrcB,
  output logic [3:0]       aluControl,
  output logic             regWrite,
  output logic [1:0]       wbSel,
  output logic [WIDTH-1:0] retired,
  output logic             illegal,
  output logic             timeout,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWR  = 4'd4,
    ST_MEMWB  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_ALUWB  = 4'd7,
    ST_BRANCH = 4'd8,
    ST_JAL    = 4'd9,
    ST_TRAP   = 4'd10
  } state_t;

  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_rtype  = 7'b0110011;
  localparam logic [6:0] c_op_itype  = 7'b0010011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;

  localparam logic [3:0] c_alu_add  = 4'd0;
  localparam logic [3:0] c_alu_sub  = 4'd1;
  localparam logic [3:0] c_alu_and  = 4'd2;
  localparam logic [3:0] c_alu_or   = 4'd3;
  localparam logic [3:0] c_alu_xor  = 4'd4;
  localparam logic [3:0] c_alu_sll  = 4'd5;
  localparam logic [3:0] c_alu_srl  = 4'd6;
  localparam logic [3:0] c_alu_sra  = 4'd7;
  localparam logic [3:0] c_alu_slt  = 4'd8;
  localparam logic [3:0] c_alu_sltu = 4'd9;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] retired_q, retired_d;
  logic             illegal_q, illegal_d;
  logic             retire;
  logic [3:0]       exec_alu;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       bit30;
  logic       is_rtype;
  logic       unused_instr_bits;

  assign opcode            = instruction[6:0];
  assign funct3            = instruction[14:12];
  assign bit30             = instruction[30];
  assign is_rtype          = (opcode == c_op_rtype);
  assign unused_instr_bits = ^{instruction[31], instruction[29:15], instruction[11:7]};

`ifdef RV_MC_TIMEOUT_EN
  localparam int                 c_cnt_w    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);
  logic [c_cnt_w-1:0] wait_cnt_q, wait_cnt_d;
  logic               timeout_q, timeout_d;
  assign timeout = timeout_q;
`else
  localparam int c_unused_timeout = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  assign retired = retired_q;
  assign illegal = illegal_q;
  assign state   = state_q;

  // ALU operation for EXEC, from funct3 and bit 30 (SUB only for R-type, SRA for both)
  always_comb begin
    exec_alu = c_alu_add;
    case (funct3)
      3'b000:  exec_alu = (is_rtype && bit30) ? c_alu_sub : c_alu_add;
      3'b001:  exec_alu = c_alu_sll;
      3'b010:  exec_alu = c_alu_slt;
      3'b011:  exec_alu = c_alu_sltu;
      3'b100:  exec_alu = c_alu_xor;
      3'b101:  exec_alu = bit30 ? c_alu_sra : c_alu_srl;
      3'b110:  exec_alu = c_alu_or;
      default: exec_alu = c_alu_and;
    endcase
  end

  // Next-state, datapath controls, retire and sticky flags
  always_comb begin
    state_d    = state_q;
    retired_d  = retired_q;
    illegal_d  = illegal_q;
    retire     = 1'b0;
    memReq     = 1'b0;
    memWe      = 1'b0;
    memAddrSel = 1'b0;
    irWrite    = 1'b0;
    pcWrite    = 1'b0;
    pcSrc      = 1'b0;
    aluSrcA    = 2'd0;
    aluSrcB    = 2'd0;
    aluControl = c_alu_add;
    regWrite   = 1'b0;
    wbSel      = 2'd0;
`ifdef RV_MC_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
`endif
    case (state_q)
      ST_FETCH: begin
        memReq  = 1'b1;
        aluSrcB = 2'd2;
        if (memReady) begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        // ALUOut captures oldPC + imm so BRANCH/JAL can load it later
        aluSrcA = 2'd1;
        aluSrcB = 2'd1;
        case (opcode)
          c_op_load, c_op_store:  state_d = ST_MEMADR;
          c_op_rtype, c_op_itype: state_d = ST_EXEC;
          c_op_branch:            state_d = ST_BRANCH;
          c_op_jal:               state_d = ST_JAL;
          default: begin
            state_d   = ST_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      ST_MEMADR: begin
        aluSrcA = 2'd2;
        aluSrcB = 2'd1;
        state_d = (opcode == c_op_load) ? ST_MEMRD : ST_MEMWR;
      end
      ST_MEMRD: begin
        memReq     = 1'b1;
        memAddrSel = 1'b1;
        if (memReady) state_d = ST_MEMWB;
      end
      ST_MEMWR: begin
        memReq     = 1'b1;
        memWe      = 1'b1;
        memAddrSel = 1'b1;
        if (memReady) begin
          retire  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_MEMWB: begin
        regWrite = 1'b1;
        wbSel    = 2'd1;
        retire   = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_EXEC: begin
        aluSrcA    = 2'd2;
        aluSrcB    = is_rtype ? 2'd0 : 2'd1;
        aluControl = exec_alu;
        state_d    = ST_ALUWB;
      end
      ST_ALUWB: begin
        regWrite = 1'b1;
        retire   = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_BRANCH: begin
        aluSrcA    = 2'd2;
        aluControl = c_alu_sub;
        pcSrc      = 1'b1;
        case (funct3)
          3'b000: begin
            pcWrite = zero;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
          3'b001: begin
            pcWrite = ~zero;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
          default: begin
            state_d   = ST_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      ST_JAL: begin
        regWrite = 1'b1;
        wbSel    = 2'd2;
        pcWrite  = 1'b1;
        pcSrc    = 1'b1;
        retire   = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase
`ifdef RV_MC_TIMEOUT_EN
    // Watchdog: a stalled access that reaches the limit diverts to TRAP
    if (memReq && !memReady) begin
      if (wait_cnt_q == c_cnt_last) begin
        state_d   = ST_TRAP;
        timeout_d = 1'b1;
      end
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
    if ((state_d != state_q) &&
        (state_d == ST_FETCH || state_d == ST_MEMRD || state_d == ST_MEMWR)) begin
      wait_cnt_d = '0;
    end
`endif
    if (retire) retired_d = retired_q + {{(WIDTH-1){1'b0}}, 1'b1};
    // Nothing is requested or written while reset is held
    if (rst) begin
      memReq   = 1'b0;
      memWe    = 1'b0;
      irWrite  = 1'b0;
      pcWrite  = 1'b0;
      regWrite = 1'b0;
    end
  end

  // State, retired counter and illegal flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef RV_MC_TIMEOUT_EN
  // Watchdog counter and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end
`endif

endmodule
`default_nettype wire
